// File: rtl/mod_n_seq_counter_pkg.sv
// Shared types, constants and helpers for the modulo-N sequencing counter.
package mod_n_seq_counter_pkg;

  localparam int MOD_BCD   = 10;
  localparam int MOD_HEX   = 16;
  localparam int MAX_WIDTH = 8;

  // PATTERN holds one bit per representable count value.
  function automatic int pattern_w(input int width);
    return 32'sd1 << width;
  endfunction

  // Modulo-N step in either direction.
  // Evaluated at the widest supported count width; callers truncate to their own width.
  function automatic logic [MAX_WIDTH-1:0] next_cnt(input logic [MAX_WIDTH-1:0] cnt,
                                                    input logic                 up,
                                                    input int                   modulus);
    logic [MAX_WIDTH-1:0] last;
    last = MAX_WIDTH'(modulus - 32'sd1);
    if (up) begin
      next_cnt = (cnt == last) ? {MAX_WIDTH{1'b0}} : cnt + MAX_WIDTH'(1);
    end else begin
      next_cnt = (cnt == {MAX_WIDTH{1'b0}}) ? last : cnt - MAX_WIDTH'(1);
    end
  endfunction

endpackage

// File: rtl/mod_n_seq_counter_if.sv
// Control and status bundle between a counter stage and whatever drives it.
interface mod_n_seq_counter_if #(
  parameter int WIDTH  = 4,
  parameter int WRAP_W = 8
);
  logic              EN;
  logic              UP_DN;
  logic              LOAD;
  logic [WIDTH-1:0]  LOAD_VAL;
  logic [WIDTH-1:0]  CNT;
  logic              SEQ_OUT;
  logic              TC;
  logic [WRAP_W-1:0] WRAPS;
  logic              LOAD_ERR;

  modport master (
    output EN, UP_DN, LOAD, LOAD_VAL,
    input  CNT, SEQ_OUT, TC, WRAPS, LOAD_ERR
  );

  modport slave (
    input  EN, UP_DN, LOAD, LOAD_VAL,
    output CNT, SEQ_OUT, TC, WRAPS, LOAD_ERR
  );
endinterface

// File: rtl/mod_n_seq_counter_core.sv
// Count register with load/enable priority and terminal-count detection.
module mod_n_seq_counter_core
  import mod_n_seq_counter_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int MODULUS = MOD_BCD
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] cnt,
  output logic [WIDTH-1:0] cnt_next,
  output logic             tc,
  output logic             load_bad
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] cnt_r;
  logic [WIDTH-1:0] cnt_next_s;
  logic             in_range_s;
  logic             at_end_s;
  logic             tc_s;

  // Next-state selection, priority reset > load > enable > hold.
  always_comb begin
    in_range_s = (32'(load_val) < 32'(MODULUS));
    at_end_s   = up_dn ? (cnt_r == LAST) : (cnt_r == {WIDTH{1'b0}});
    tc_s       = en & ~load & ~rst & at_end_s;
    if (rst) begin
      cnt_next_s = {WIDTH{1'b0}};
    end else if (load) begin
      if (in_range_s) begin
        cnt_next_s = load_val;
      end else begin
        cnt_next_s = {WIDTH{1'b0}};
      end
    end else if (en) begin
      cnt_next_s = WIDTH'(next_cnt(MAX_WIDTH'(cnt_r), up_dn, MODULUS));
    end else begin
      cnt_next_s = cnt_r;
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    cnt_r <= cnt_next_s;
  end

  assign cnt      = cnt_r;
  assign cnt_next = cnt_next_s;
  assign tc       = tc_s;
  assign load_bad = load & ~rst & ~in_range_s;

endmodule

// File: rtl/mod_n_seq_counter.sv
// Modulo-N up/down counter with per-count sequence bit, wrap counter and load-error flag.
module mod_n_seq_counter
  import mod_n_seq_counter_pkg::*;
#(
  parameter int                            WIDTH   = 4,
  parameter int                            MODULUS = MOD_BCD,
  parameter logic [pattern_w(WIDTH)-1:0]   PATTERN = 16'h003F,
  parameter int                            WRAP_W  = 8
) (
  input  logic               CLK,
  input  logic               RST,
  mod_n_seq_counter_if.slave bus
);

  if (WIDTH < 2 || WIDTH > MAX_WIDTH) begin : g_bad_width
    $error("mod_n_seq_counter: WIDTH out of range");
  end
  if (MODULUS < 2 || MODULUS > pattern_w(WIDTH)) begin : g_bad_modulus
    $error("mod_n_seq_counter: MODULUS out of range");
  end

  logic [WIDTH-1:0]  cnt_s;
  logic [WIDTH-1:0]  cnt_next_s;
  logic              tc_s;
  logic              load_bad_s;
  logic              seq_r;
  logic [WRAP_W-1:0] wraps_r;
  logic              load_err_r;

  mod_n_seq_counter_core #(
    .WIDTH   (WIDTH),
    .MODULUS (MODULUS)
  ) u_core (
    .clk      (CLK),
    .rst      (RST),
    .en       (bus.EN),
    .up_dn    (bus.UP_DN),
    .load     (bus.LOAD),
    .load_val (bus.LOAD_VAL),
    .cnt      (cnt_s),
    .cnt_next (cnt_next_s),
    .tc       (tc_s),
    .load_bad (load_bad_s)
  );

  // SEQ_OUT looks up the next count so it lands on the same edge as CNT.
  always_ff @(posedge CLK) begin
    if (RST) begin
      seq_r      <= PATTERN[0];
      wraps_r    <= {WRAP_W{1'b0}};
      load_err_r <= 1'b0;
    end else begin
      seq_r <= PATTERN[cnt_next_s];
      if (tc_s) begin
        wraps_r <= wraps_r + WRAP_W'(1);
      end else begin
        wraps_r <= wraps_r;
      end
      if (load_bad_s) begin
        load_err_r <= 1'b1;
      end else begin
        load_err_r <= load_err_r;
      end
    end
  end

  assign bus.CNT      = cnt_s;
  assign bus.SEQ_OUT  = seq_r;
  assign bus.TC       = tc_s;
  assign bus.WRAPS    = wraps_r;
  assign bus.LOAD_ERR = load_err_r;

endmodule

// File: tb/tb_mod_n_seq_counter.sv
// Drives a BCD-default stage and a hex/A5A5/2-bit-wrap stage with shared stimulus against arithmetic models.
module tb_mod_n_seq_counter;

  localparam int MA = 10;
  localparam int MB = 16;
  localparam int WWA = 8;
  localparam int WWB = 2;

  logic CLK = 1'b0;
  logic RST;
  int   total = 0;
  int   bad = 0;

  logic [15:0] pat_a = 16'h003F;
  logic [15:0] pat_b = 16'hA5A5;
  int ca, wa, cb, wb;
  bit ea, eb;

  always #5 CLK = ~CLK;

  mod_n_seq_counter_if #(.WIDTH(4), .WRAP_W(WWA)) ba ();
  mod_n_seq_counter_if #(.WIDTH(4), .WRAP_W(WWB)) bb ();

  assign bb.EN       = ba.EN;
  assign bb.UP_DN    = ba.UP_DN;
  assign bb.LOAD     = ba.LOAD;
  assign bb.LOAD_VAL = ba.LOAD_VAL;

  mod_n_seq_counter dut_a (.CLK(CLK), .RST(RST), .bus(ba));

  mod_n_seq_counter #(
    .WIDTH(4), .MODULUS(MB), .PATTERN(16'hA5A5), .WRAP_W(WWB)
  ) dut_b (.CLK(CLK), .RST(RST), .bus(bb));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d at t=%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit exp_tc(int c, int m, bit r, bit e, bit u, bit l);
    return !r && !l && e && (u ? (c == m - 1) : (c == 0));
  endfunction

  function automatic void upd(inout int c, inout int w, inout bit er, input int m, input int ww,
                              input bit r, input bit e, input bit u, input bit l, input int lv);
    if (r) begin
      c = 0; w = 0; er = 1'b0;
    end else if (l) begin
      if (lv < m) c = lv;
      else begin c = 0; er = 1'b1; end
    end else if (e) begin
      if (exp_tc(c, m, r, e, u, l)) w = (w + 1) % (1 << ww);
      c = u ? (c + 1) % m : (c + m - 1) % m;
    end
  endfunction

  task automatic step(input bit r, input bit e, input bit u, input bit l, input int lv);
    RST = r; ba.EN = e; ba.UP_DN = u; ba.LOAD = l; ba.LOAD_VAL = 4'(lv);
    #1;
    chk("tc_a", 32'(ba.TC), 32'(exp_tc(ca, MA, r, e, u, l)));
    chk("tc_b", 32'(bb.TC), 32'(exp_tc(cb, MB, r, e, u, l)));
    upd(ca, wa, ea, MA, WWA, r, e, u, l, lv);
    upd(cb, wb, eb, MB, WWB, r, e, u, l, lv);
    @(posedge CLK);
    @(negedge CLK);
    chk("cnt_a", 32'(ba.CNT), 32'(ca));
    chk("seq_a", 32'(ba.SEQ_OUT), 32'((pat_a >> ca) & 16'd1));
    chk("wraps_a", 32'(ba.WRAPS), 32'(wa));
    chk("lerr_a", 32'(ba.LOAD_ERR), 32'(ea));
    chk("cnt_b", 32'(bb.CNT), 32'(cb));
    chk("seq_b", 32'(bb.SEQ_OUT), 32'((pat_b >> cb) & 16'd1));
    chk("wraps_b", 32'(bb.WRAPS), 32'(wb));
    chk("lerr_b", 32'(bb.LOAD_ERR), 32'(eb));
  endtask

  initial begin
    ca = 0; wa = 0; cb = 0; wb = 0; ea = 1'b0; eb = 1'b0;
    RST = 1'b1; ba.EN = 1'b0; ba.UP_DN = 1'b1; ba.LOAD = 1'b0; ba.LOAD_VAL = 4'd0;

    // reset state, then plain up count across two decade wraps
    step(1, 0, 1, 0, 0);
    for (int i = 0; i < 22; i++) step(0, 1, 1, 0, 0);

    // down count from reset: first edge wraps to MODULUS-1
    step(1, 0, 1, 0, 0);
    for (int i = 0; i < 12; i++) step(0, 1, 0, 0, 0);

    // loads: in range with EN high, then out of range, then sticky error
    step(0, 1, 1, 1, 7);
    step(0, 1, 1, 1, 12);
    for (int i = 0; i < 4; i++) step(0, 1, 1, 0, 0);

    // hold at CNT=4
    step(0, 0, 1, 1, 4);
    for (int i = 0; i < 5; i++) step(0, 0, i % 2, 0, 0);

    // hex stage full sweep: four wraps of a 2-bit wrap counter
    step(1, 0, 1, 0, 0);
    for (int i = 0; i < 64; i++) step(0, 1, 1, 0, 0);

    // reset colliding with load and enable mid-count
    step(0, 1, 1, 1, 13);
    for (int i = 0; i < 15; i++) step(0, 1, 1, 0, 0);
    step(1, 1, 1, 1, 3);

    // randomized traffic
    for (int i = 0; i < 300; i++) begin
      step($urandom_range(0, 39) == 0, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
           $urandom_range(0, 7) == 0, int'($urandom_range(0, 15)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
